pipe_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage MIPS pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) and the PC register.
- Each cycle it generates every per-stage write enable and flush from hazard, exception, cache-busy and multicycle-divide inputs.
- It also owns the divider busy countdown FSM.
- Pipeline registers give flush priority over write enable.

---
 rtl/pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline, including the divider busy countdown.
// Optional performance counters are enabled with `define PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 34
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_LoadUse,
    input  logic             EXE_BranchTaken,
    input  logic             EXE_DivStart,
    input  logic             MEM_ExcValid,
    input  logic             ICache_Busy,
    input  logic             DCache_Busy,
    output logic             PC_Wr,
    output logic             IF_IDWr,
    output logic             ID_EXEWr,
    output logic             EXE_MEMWr,
    output logic             MEM_WBWr,
    output logic             IFID_Flush,
    output logic             IDEXE_Flush,
    output logic             EXEMEM_Flush,
    output logic             MEMWB_Flush,
    output logic [1:0]       PC_Sel,
    output logic             Div_Busy,
    output logic             Div_Done
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
`endif
);

    localparam int unsigned CW = 6;
    localparam int unsigned WR_W = 5;
    localparam int unsigned FL_W = 4;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_EXC = 2'b10;

    // Write-enable order: {PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB}
    localparam logic [WR_W-1:0] WR_ALL   = 5'b11111;
    localparam logic [WR_W-1:0] WR_NONE  = 5'b00000;
    localparam logic [WR_W-1:0] WR_DIV   = 5'b00011;
    localparam logic [WR_W-1:0] WR_LDUSE = 5'b00111;
    localparam logic [WR_W-1:0] WR_IMISS = 5'b01111;

    // Flush order: {IF/ID, ID/EXE, EXE/MEM, MEM/WB}
    localparam logic [FL_W-1:0] FL_NONE = 4'b0000;
    localparam logic [FL_W-1:0] FL_ALL  = 4'b1111;
    localparam logic [FL_W-1:0] FL_IFID = 4'b1000;
    localparam logic [FL_W-1:0] FL_IDEX = 4'b0100;
    localparam logic [FL_W-1:0] FL_EXME = 4'b0010;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div_act_q, div_act_d;

    logic [WR_W-1:0] wr;
    logic [FL_W-1:0] fl;
    logic [1:0]      pc_sel;
    logic            div_busy;
    logic            div_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            div_act_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
        end
    end

    // div_act_q remembers a divide parked behind a D-cache stall so it resumes afterwards
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        wr        = WR_ALL;
        fl        = FL_NONE;
        pc_sel    = SEL_SEQ;
        div_busy  = 1'b0;
        div_done  = 1'b0;

        if (!rst) begin
            wr        = WR_NONE;
            fl        = FL_ALL;
            state_d   = RUN;
            cnt_d     = '0;
            div_act_d = 1'b0;
        end else if (MEM_ExcValid) begin
            fl        = FL_ALL;
            pc_sel    = SEL_EXC;
            state_d   = RUN;
            cnt_d     = '0;
            div_act_d = 1'b0;
        end else if (DCache_Busy) begin
            wr       = WR_NONE;
            div_busy = div_act_q;
            state_d  = MEM_WAIT;
        end else if (state_q == DIV_WAIT || (state_q == MEM_WAIT && div_act_q)) begin
            if (cnt_q != '0) begin
                wr       = WR_DIV;
                fl       = FL_EXME;
                div_busy = 1'b1;
                cnt_d    = cnt_q - CW'(1);
                state_d  = DIV_WAIT;
            end else begin
                div_done  = 1'b1;
                div_act_d = 1'b0;
                state_d   = RUN;
            end
        end else begin
            state_d = RUN;
            if (EXE_DivStart) begin
                wr        = WR_DIV;
                fl        = FL_EXME;
                div_busy  = 1'b1;
                cnt_d     = CW'(DIV_CYCLES - 2);
                div_act_d = 1'b1;
                state_d   = DIV_WAIT;
            end else if (EXE_BranchTaken) begin
                // delay slot sits in ID and proceeds; only the wrong-path fetch is dropped
                fl     = FL_IFID;
                pc_sel = SEL_BR;
            end else if (ID_LoadUse) begin
                wr = WR_LDUSE;
                fl = FL_IDEX;
            end else if (ICache_Busy) begin
                wr = WR_IMISS;
                fl = FL_IFID;
            end
        end
    end

    assign PC_Wr        = wr[4];
    assign IF_IDWr      = wr[3];
    assign ID_EXEWr     = wr[2];
    assign EXE_MEMWr    = wr[1];
    assign MEM_WBWr     = wr[0];
    assign IFID_Flush   = fl[3];
    assign IDEXE_Flush  = fl[2];
    assign EXEMEM_Flush = fl[1];
    assign MEMWB_Flush  = fl[0];
    assign PC_Sel       = pc_sel;
    assign Div_Busy     = div_busy;
    assign Div_Done     = div_done;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Free-running wrap-around event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!wr[4]) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (MEM_ExcValid) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against an event-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned DIVC = 34;
`ifdef PIPE_PERF_CNT_EN
    localparam int unsigned PCW = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ID_LoadUse = 1'b0, EXE_BranchTaken = 1'b0, EXE_DivStart = 1'b0;
    logic MEM_ExcValid = 1'b0, ICache_Busy = 1'b0, DCache_Busy = 1'b0;
    logic PC_Wr, IF_IDWr, ID_EXEWr, EXE_MEMWr, MEM_WBWr;
    logic IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEMWB_Flush;
    logic [1:0] PC_Sel;
    logic Div_Busy, Div_Done;
`ifdef PIPE_PERF_CNT_EN
    logic [PCW-1:0] Stall_Cnt, Flush_Cnt;
`endif

    pipe_hazard_ctrl #(
        .DIV_CYCLES(DIVC)
`ifdef PIPE_PERF_CNT_EN
        , .CNT_W(PCW)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .ID_LoadUse(ID_LoadUse), .EXE_BranchTaken(EXE_BranchTaken),
        .EXE_DivStart(EXE_DivStart), .MEM_ExcValid(MEM_ExcValid),
        .ICache_Busy(ICache_Busy), .DCache_Busy(DCache_Busy),
        .PC_Wr(PC_Wr), .IF_IDWr(IF_IDWr), .ID_EXEWr(ID_EXEWr),
        .EXE_MEMWr(EXE_MEMWr), .MEM_WBWr(MEM_WBWr),
        .IFID_Flush(IFID_Flush), .IDEXE_Flush(IDEXE_Flush),
        .EXEMEM_Flush(EXEMEM_Flush), .MEMWB_Flush(MEMWB_Flush),
        .PC_Sel(PC_Sel), .Div_Busy(Div_Busy), .Div_Done(Div_Done)
`ifdef PIPE_PERF_CNT_EN
        , .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
    );

    always #5 clk = ~clk;

    // {PC,IF/ID,ID/EXE,EXE/MEM,MEM/WB Wr, IFID,IDEXE,EXEMEM,MEMWB Flush, PC_Sel, Busy, Done}
    logic [12:0] obs;
    assign obs = {PC_Wr, IF_IDWr, ID_EXEWr, EXE_MEMWr, MEM_WBWr,
                  IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEMWB_Flush,
                  PC_Sel, Div_Busy, Div_Done};

    localparam logic [12:0] V_RST  = 13'b00000_1111_00_00;
    localparam logic [12:0] V_IDLE = 13'b11111_0000_00_00;
    localparam logic [12:0] V_EXC  = 13'b11111_1111_10_00;

    int n_vec = 0;
    int n_err = 0;
    logic [12:0] last_obs;

    // Reference: divide tracked as count of occupied EXE cycles already spent
    bit m_in_div = 1'b0, n_in_div;
    int m_k = 0, n_k;
    int m_stall = 0, m_flush = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval(input bit lu, br, ds, ex, ic, dc, output logic [12:0] e);
        logic [4:0] w;
        logic [3:0] f;
        logic [1:0] s;
        logic b, d;
        w = 5'b11111; f = 4'b0000; s = 2'b00; b = 1'b0; d = 1'b0;
        n_in_div = m_in_div;
        n_k = m_k;
        if (ex) begin
            f = 4'b1111; s = 2'b10; n_in_div = 1'b0; n_k = 0;
        end else if (dc) begin
            w = 5'b00000; b = m_in_div;
        end else if (m_in_div) begin
            if (m_k < int'(DIVC) - 1) begin
                w = 5'b00011; f = 4'b0010; b = 1'b1; n_k = m_k + 1;
            end else begin
                d = 1'b1; n_in_div = 1'b0; n_k = 0;
            end
        end else if (ds) begin
            w = 5'b00011; f = 4'b0010; b = 1'b1; n_in_div = 1'b1; n_k = 1;
        end else if (br) begin
            f = 4'b1000; s = 2'b01;
        end else if (lu) begin
            w = 5'b00111; f = 4'b0100;
        end else if (ic) begin
            w = 5'b01111; f = 4'b1000;
        end
        e = {w, f, s, b, d};
    endtask

    // One clock: drive, check at negedge, advance model after posedge
    task automatic step(input bit lu, br, ds, ex, ic, dc);
        logic [12:0] e;
        ID_LoadUse = lu; EXE_BranchTaken = br; EXE_DivStart = ds;
        MEM_ExcValid = ex; ICache_Busy = ic; DCache_Busy = dc;
        @(negedge clk);
        model_eval(lu, br, ds, ex, ic, dc, e);
        last_obs = obs;
        chk("outs", 32'(obs), 32'(e));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", 32'(Stall_Cnt), 32'(m_stall));
        chk("flush_cnt", 32'(Flush_Cnt), 32'(m_flush));
`endif
        @(posedge clk);
        #1;
        m_in_div = n_in_div;
        m_k = n_k;
        if (!e[12]) m_stall = (m_stall + 1) % 16;
        if (ex) m_flush = (m_flush + 1) % 16;
    endtask

    task automatic do_reset(input int n);
        ID_LoadUse = 1'b0; EXE_BranchTaken = 1'b0; EXE_DivStart = 1'b0;
        MEM_ExcValid = 1'b0; ICache_Busy = 1'b0; DCache_Busy = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_outs", 32'(obs), 32'(V_RST));
        m_in_div = 1'b0; m_k = 0; m_stall = 0; m_flush = 0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nb, done_at, ndone, nfrz, dc_left;
        bit dc;
        logic [12:0] v;

        // reset held for 3 cycles, then idle
        @(posedge clk);
        #1;
        do_reset(3);
        step(0, 0, 0, 0, 0, 0);
        chk("idle_after_rst", 32'(last_obs), 32'(V_IDLE));

        // unstalled divide
        nb = 0; done_at = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, i == 1, 0, 0, 0);
            if (last_obs[1]) nb++;
            if (last_obs[0] && done_at == 0) done_at = i;
            if (i == 34) chk("div_done_wr", 32'(last_obs[12:8]), 32'h1f);
        end
        chk("div_busy_cycles", 32'(nb), 32'(DIVC - 1));
        chk("div_done_cycle", 32'(done_at), 32'(DIVC));

        // exception at divide cycle 10
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, i == 1, i == 10, 0, 0);
            if (last_obs[0]) ndone++;
            if (i == 10) chk("exc_outs", 32'(last_obs), 32'(V_EXC));
            if (i == 11) chk("exc_next_run", 32'(last_obs), 32'(V_IDLE));
        end
        chk("exc_no_done", 32'(ndone), 32'd0);

        // D-cache freeze for 5 cycles mid-divide
        done_at = 0; nfrz = 0;
        for (int i = 1; i <= 45; i++) begin
            step(0, 0, i == 1, 0, 0, i >= 5 && i <= 9);
            if (last_obs[12:8] == 5'b00000) nfrz++;
            if (last_obs[0] && done_at == 0) done_at = i;
        end
        chk("dc_frozen_cycles", 32'(nfrz), 32'd5);
        chk("dc_done_cycle", 32'(done_at), 32'(DIVC + 5));

        // load-use then branch
        step(1, 0, 0, 0, 0, 0);
        v = last_obs;
        chk("lu_pc_wr", 32'(v[12]), 32'd0);
        chk("lu_idexe_flush", 32'(v[6]), 32'd1);
        step(0, 1, 0, 0, 0, 0);
        v = last_obs;
        chk("br_pc_sel", 32'(v[3:2]), 32'd1);
        chk("br_idexe_flush", 32'(v[6]), 32'd0);
        chk("br_ifid_flush", 32'(v[7]), 32'd1);

        // branch together with I-cache miss
        step(0, 1, 0, 0, 1, 0);
        chk("br_ic_outs", 32'(last_obs), 32'(13'b11111_1000_01_00));

        // reset in the middle of a divide
        for (int i = 1; i <= 5; i++) step(0, 0, i == 1, 0, 0, 0);
        do_reset(2);
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (last_obs[0]) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);

        // randomized traffic
        dc_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 799) == 0) do_reset(2);
            if (dc_left == 0 && $urandom_range(0, 15) == 0) dc_left = int'($urandom_range(1, 6));
            dc = (dc_left != 0);
            if (dc_left != 0) dc_left--;
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 5) == 0, dc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
